// File: rtl/platform_scroller_if.sv
// Platform scroller bus: view-update request, collision report and slot outputs.
// master drives newView/minY/hasCollide/collisionIdx; slave drives slot state, busy, updateDone.
interface platform_scroller_if #(
    parameter int NUM_BLOCKS = 16,
    parameter int COORD_W    = 32,
    parameter int IDX_W      = $clog2(NUM_BLOCKS)
);
    logic                          newView;
    logic [COORD_W-1:0]            minY;
    logic                          hasCollide;
    logic [IDX_W-1:0]              collisionIdx;
    logic [NUM_BLOCKS*COORD_W-1:0] blocksX;
    logic [NUM_BLOCKS*COORD_W-1:0] blocksY;
    logic [NUM_BLOCKS-1:0]         isBlockActive;
    logic [NUM_BLOCKS-1:0]         isBreakable;
    logic                          busy;
    logic                          updateDone;

    modport master (
        output newView, minY, hasCollide, collisionIdx,
        input  blocksX, blocksY, isBlockActive, isBreakable,
        input  busy, updateDone
    );

    modport slave (
        input  newView, minY, hasCollide, collisionIdx,
        output blocksX, blocksY, isBlockActive, isBreakable,
        output busy, updateDone
    );
endinterface

// File: rtl/platform_scroller.sv
// Platform slot pool: recycles slots below the view to above the top platform, one slot per clock.
// Ports: clk, reset (async active-low), bus (platform_scroller_if.slave). Option: MOVING_PLATFORMS_EN.
module platform_scroller #(
    parameter int          SCREEN_WIDTH  = 400,
    parameter int          SCREEN_HEIGHT = 700,
    parameter int          BLOCK_WIDTH   = 40,
    parameter int          BLOCK_HEIGHT  = 5,
    parameter int          NUM_BLOCKS    = 16,
    parameter int          COORD_W       = 32,
    parameter int          IDX_W         = $clog2(NUM_BLOCKS),
    parameter int          ROW_GAP       = 44,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1,
    parameter int          MOVE_STEP     = 4
) (
    input logic                clk,
    input logic                reset,
    platform_scroller_if.slave bus
);

    localparam int BLOCK_IN_WIDTH = SCREEN_WIDTH / BLOCK_WIDTH;
    localparam int SLOT_W         = $clog2(NUM_BLOCKS);

    if (LFSR_SEED == 16'h0 || BLOCK_IN_WIDTH < 1 ||
        SCREEN_HEIGHT < BLOCK_HEIGHT || MOVE_STEP >= SCREEN_WIDTH) begin : g_cfg_err
        $error("platform_scroller: invalid configuration");
    end

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    state_t state_q;
    state_t state_n;
    logic   busy_q;
    logic   busy_n;
    logic   done_q;
    logic   done_n;

    logic [COORD_W-1:0]    x_q [NUM_BLOCKS];
    logic [COORD_W-1:0]    y_q [NUM_BLOCKS];
    logic [NUM_BLOCKS-1:0] act_q;
    logic [NUM_BLOCKS-1:0] brk_q;
    logic [COORD_W-1:0]    top_q;
    logic [COORD_W-1:0]    miny_q;
    logic [15:0]           lfsr_q;
    logic [SLOT_W-1:0]     ptr_q;

    logic                  last_slot;
    logic                  rec_hit;
    logic [COORD_W-1:0]    new_top;
    logic [COORD_W-1:0]    rec_x;
    logic [15:0]           lfsr_nx;
    logic                  coll_ok;
    logic [SLOT_W-1:0]     coll_slot;
    logic [NUM_BLOCKS-1:0] coll_mask;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
        end
    end

    assign last_slot = (ptr_q == SLOT_W'(NUM_BLOCKS - 1));

    always_comb begin
        state_n = state_q;
        unique case (state_q)
            IDLE:    if (bus.newView) state_n = SCAN;
            SCAN:    if (last_slot) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered: decode the state being entered.
    always_comb begin
        busy_n = (state_n != IDLE);
        done_n = (state_n == DONE);
    end

    // ---------------- slot datapath ----------------
    assign new_top = top_q + COORD_W'(ROW_GAP);
    assign rec_x   = COORD_W'(lfsr_q % 16'(BLOCK_IN_WIDTH))
                   * COORD_W'(BLOCK_WIDTH);
    // Fibonacci form of x^16+x^14+x^13+x^11+1, shifting right.
    assign lfsr_nx = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5],
                      lfsr_q[15:1]};
    assign rec_hit = (state_q == SCAN) && (y_q[ptr_q] < miny_q);

    assign coll_ok   = (int'(bus.collisionIdx) < NUM_BLOCKS);
    assign coll_slot = SLOT_W'(bus.collisionIdx);

    always_comb begin
        coll_mask = '0;
        if (bus.hasCollide && coll_ok)
            coll_mask[coll_slot] = act_q[coll_slot] & brk_q[coll_slot];
    end

`ifdef MOVING_PLATFORMS_EN
    localparam logic [COORD_W-1:0] X_MAX = COORD_W'(SCREEN_WIDTH - BLOCK_WIDTH);
    localparam logic [COORD_W-1:0] STEP  = COORD_W'(MOVE_STEP);

    // dir_q: 0 moves right (+), 1 moves left (-)
    logic [NUM_BLOCKS-1:0] dir_q;
    logic [NUM_BLOCKS-1:0] mv_en;
    logic [NUM_BLOCKS-1:0] mv_dir;
    logic [COORD_W-1:0]    mv_x [NUM_BLOCKS];

    // Reaching a wall clamps there and reverses for the next view.
    always_comb begin
        for (int i = 0; i < NUM_BLOCKS; i++) begin
            mv_en[i]  = (i % 2 == 1) && act_q[i] && !brk_q[i];
            mv_x[i]   = x_q[i];
            mv_dir[i] = dir_q[i];
            if (!dir_q[i]) begin
                if (x_q[i] + STEP >= X_MAX) begin
                    mv_x[i]   = X_MAX;
                    mv_dir[i] = 1'b1;
                end else begin
                    mv_x[i] = x_q[i] + STEP;
                end
            end else begin
                if (x_q[i] <= STEP) begin
                    mv_x[i]   = '0;
                    mv_dir[i] = 1'b0;
                end else begin
                    mv_x[i] = x_q[i] - STEP;
                end
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_BLOCKS; i++) begin
                x_q[i] <= COORD_W'(((i * 3) % BLOCK_IN_WIDTH) * BLOCK_WIDTH);
                y_q[i] <= COORD_W'(i * ROW_GAP);
            end
            act_q  <= '1;
            brk_q  <= '0;
            top_q  <= COORD_W'((NUM_BLOCKS - 1) * ROW_GAP);
            miny_q <= '0;
            lfsr_q <= LFSR_SEED;
            ptr_q  <= '0;
`ifdef MOVING_PLATFORMS_EN
            dir_q  <= '0;
`endif
        end else begin
            if (state_q == IDLE && bus.newView) begin
                miny_q <= bus.minY;
                ptr_q  <= '0;
            end else if (state_q == SCAN) begin
                ptr_q <= ptr_q + SLOT_W'(1);
            end

            if (rec_hit) begin
                top_q  <= new_top;
                lfsr_q <= lfsr_nx;
            end

            // A recycle on the collided slot wins and leaves it active.
            for (int i = 0; i < NUM_BLOCKS; i++) begin
                if (rec_hit && ptr_q == SLOT_W'(i)) begin
                    y_q[i]   <= new_top;
                    x_q[i]   <= rec_x;
                    brk_q[i] <= lfsr_q[0];
                    act_q[i] <= 1'b1;
`ifdef MOVING_PLATFORMS_EN
                    dir_q[i] <= 1'b0;
`endif
                end else begin
                    if (coll_mask[i])
                        act_q[i] <= 1'b0;
`ifdef MOVING_PLATFORMS_EN
                    if (state_q == DONE && mv_en[i]) begin
                        x_q[i]   <= mv_x[i];
                        dir_q[i] <= mv_dir[i];
                    end
`endif
                end
            end
        end
    end

    // ---------------- output packing ----------------
    logic [NUM_BLOCKS*COORD_W-1:0] x_flat;
    logic [NUM_BLOCKS*COORD_W-1:0] y_flat;

    always_comb begin
        x_flat = '0;
        y_flat = '0;
        for (int i = 0; i < NUM_BLOCKS; i++) begin
            x_flat[i*COORD_W +: COORD_W] = x_q[i];
            y_flat[i*COORD_W +: COORD_W] = y_q[i];
        end
    end

    assign bus.blocksX       = x_flat;
    assign bus.blocksY       = y_flat;
    assign bus.isBlockActive = act_q;
    assign bus.isBreakable   = brk_q;
    assign bus.busy          = busy_q;
    assign bus.updateDone    = done_q;

endmodule
